// File: rtl/uart_pkg.sv
// Shared UART types and defaults.
package uart_pkg;
    typedef logic [7:0] uart_byte_t;

    localparam int UART_RX_FIFO_DEPTH_DEF = 16;
    localparam int CLKS_PER_BIT           = 87;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Byte storage for the receive FIFO: one write port, one registered read port.
module uart_rx_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Read register holds its value when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART receiver and the register block.
// Writes are taken on the rising edge of i_Wr_Valid; reads are one-cycle pops.
// Optional sticky overflow flag: define UART_RX_FIFO_OVF_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH_DEF,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             i_Clock,
    input  logic             rst,
    input  logic             i_Wr_Valid,
    input  logic [WIDTH-1:0] i_Wr_Data,
    output logic             wr_ready,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    o_Count,
    input  logic             i_Rd_En,
    output logic [WIDTH-1:0] o_Rd_Data,
    output logic             o_Rd_Valid
`ifdef UART_RX_FIFO_OVF_EN
    ,
    output logic             o_Overflow,
    input  logic             i_Ovf_Clr
`endif
);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          wr_prev;
    logic          armed;  // low until the first edge after reset
    logic          wr_evt, wr_acc, rd_acc;

    // Edge detect; suppressed on the first edge after reset so a level
    // still high at release only primes wr_prev.
    assign wr_evt = i_Wr_Valid & ~wr_prev & armed;
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign wr_acc = wr_evt & ~full;
    assign rd_acc = i_Rd_En & ~empty;
    assign o_Count = count;

    // Next occupancy; simultaneous accept of both leaves it unchanged.
    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc)      count_next = count + 1'b1;
        else if (!wr_acc && rd_acc) count_next = count - 1'b1;
    end

    // Pointers, count, edge-detect history and receiver throttle.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wr_prev  <= 1'b0;
            armed    <= 1'b0;
            wr_ready <= 1'b0;
        end else begin
            armed    <= 1'b1;
            wr_prev  <= i_Wr_Valid;
            count    <= count_next;
            wr_ready <= (count_next != CW'(DEPTH));
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Read valid pulse aligned with the registered read data.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst) o_Rd_Valid <= 1'b0;
        else     o_Rd_Valid <= rd_acc;
    end

`ifdef UART_RX_FIFO_OVF_EN
    // Sticky flag for dropped writes; a set beats a same-cycle clear.
    always_ff @(posedge i_Clock or posedge rst) begin
        if (rst)                o_Overflow <= 1'b0;
        else if (wr_evt & full) o_Overflow <= 1'b1;
        else if (i_Ovf_Clr)     o_Overflow <= 1'b0;
    end
`endif

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (i_Clock),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (i_Wr_Data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (o_Rd_Data)
    );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo (DEPTH 16, WIDTH 8).
// Overflow checks are built only when UART_RX_FIFO_OVF_EN is defined.
module tb_uart_rx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, full, empty;
    logic [4:0] count;
    logic       rd_en = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
`ifdef UART_RX_FIFO_OVF_EN
    logic       ovf;
    logic       ovf_clr = 1'b0;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .i_Clock    (clk),
        .rst        (rst),
        .i_Wr_Valid (wr_valid),
        .i_Wr_Data  (wr_data),
        .wr_ready   (wr_ready),
        .full       (full),
        .empty      (empty),
        .o_Count    (count),
        .i_Rd_En    (rd_en),
        .o_Rd_Data  (rd_data),
        .o_Rd_Valid (rd_valid)
`ifdef UART_RX_FIFO_OVF_EN
        ,
        .o_Overflow (ovf),
        .i_Ovf_Clr  (ovf_clr)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_vld"}, rd_valid, 1);
        check({tag, "_dat"}, rd_data, exp);
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_wr_ready", wr_ready, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        tick();
        rst = 1'b0;
        check("rel_wr_ready_pre", wr_ready, 0);
        tick();
        check("rel_wr_ready", wr_ready, 1);
        check("rel_empty", empty, 1);
        check("rel_count", count, 0);

        // Read while empty is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("empty_rd_valid", rd_valid, 0);
        check("empty_rd_data", rd_data, 0);

        // Level held for 20 cycles is a single write
        wr_data  = 8'hA5;
        wr_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("level_count", count, 1);
        check("level_empty", empty, 0);
        wr_valid = 1'b0;
        tick();
        pop_check("level_rd", 8'hA5);
        tick();
        check("level_pulse_end", rd_valid, 0);
        check("level_empty_after", empty, 1);

        // Empty read holds previous data
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("hold_rd_valid", rd_valid, 0);
        check("hold_rd_data", rd_data, 8'hA5);

        // Fill to full
        for (int i = 0; i < 15; i++) push(8'(i));
        check("fill15_count", count, 15);
        check("fill15_full", full, 0);
        check("fill15_wr_ready", wr_ready, 1);
        wr_data  = 8'h0F;
        wr_valid = 1'b1;
        tick();
        check("fill16_full", full, 1);
        check("fill16_wr_ready", wr_ready, 0);
        check("fill16_count", count, 16);
        wr_valid = 1'b0;
        tick();

        // 17th write dropped
        push(8'hFF);
        check("drop_count", count, 16);
        check("drop_full", full, 1);
`ifdef UART_RX_FIFO_OVF_EN
        check("ovf_set", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 0);
`endif

        // Simultaneous write and read at full: write rejected, read proceeds
        wr_data  = 8'hEE;
        wr_valid = 1'b1;
        rd_en    = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        check("fullrw_vld", rd_valid, 1);
        check("fullrw_dat", rd_data, 8'h00);
        check("fullrw_count", count, 15);
        check("fullrw_wr_ready", wr_ready, 1);

        // Back-to-back reads drain 0x01..0x0F in order
        rd_en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            check("drain_vld", rd_valid, 1);
            check("drain_dat", rd_data, 32'(i));
        end
        rd_en = 1'b0;
        check("drain_empty", empty, 1);
        check("drain_count", count, 0);
        tick();
        check("drain_pulse_end", rd_valid, 0);

        // Simultaneous write and read while empty: read rejected, write taken
        wr_data  = 8'h33;
        wr_valid = 1'b1;
        rd_en    = 1'b1;
        tick();
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        check("emptyrw_vld", rd_valid, 0);
        check("emptyrw_count", count, 1);
        pop_check("emptyrw_rd", 8'h33);
        tick();

        // Wrap-around
        for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
        for (int i = 0; i < 10; i++) pop_check("wrap1", 8'(8'h30 + i));
        for (int i = 0; i < 10; i++) push(8'(8'h40 + i));
        check("wrap_count", count, 10);
        for (int i = 0; i < 10; i++) pop_check("wrap2", 8'(8'h40 + i));
        check("wrap_empty", empty, 1);

        // Reset mid-operation with the receiver level high
        for (int i = 0; i < 4; i++) push(8'(8'h60 + i));
        wr_data  = 8'h64;
        wr_valid = 1'b1;
        tick();
        check("prerst_count", count, 5);
        rst = 1'b1;
        #1;
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_wr_ready", wr_ready, 0);
        check("midrst_rd_data", rd_data, 0);
        tick();
        rst = 1'b0;
        tick();
        check("postrst_wr_ready", wr_ready, 1);
        check("postrst_count", count, 0);
        tick();
        tick();
        check("postrst_level_count", count, 0);
        wr_valid = 1'b0;
        tick();
        wr_data  = 8'h5A;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("postrst_edge_count", count, 1);
        tick();
        pop_check("postrst_rd", 8'h5A);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
